// File: rtl/lieat_idu_oitf.sv
// Outstanding Instruction Track FIFO: tracks in-flight long-latency instructions
// in dispatch order and flags RAW/WAW hazards for the instruction waiting in dispatch.
module lieat_idu_oitf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int RAW_W = 5
) (
    input  logic             clk,
    input  logic             rstn,

    input  logic             dis_ena,
    input  logic             dis_rdwen,
    input  logic [RAW_W-1:0] dis_rdidx,
    output logic [PTR_W-1:0] dis_ptr,

    input  logic             ret_ena,
    output logic [PTR_W-1:0] ret_ptr,
    output logic             ret_rdwen,
    output logic [RAW_W-1:0] ret_rdidx,

    input  logic             chk_rs1en,
    input  logic             chk_rs2en,
    input  logic             chk_rdwen,
    input  logic [RAW_W-1:0] chk_rs1idx,
    input  logic [RAW_W-1:0] chk_rs2idx,
    input  logic [RAW_W-1:0] chk_rdidx,

    output logic             oitf_raw_dep,
    output logic             oitf_waw_dep,
    output logic             oitf_empty,
    output logic             oitf_full
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [PTR_W:0]   alc_ptr;
    logic [PTR_W:0]   rtr_ptr;
    logic [DEPTH-1:0] vld;
    logic             rdwen [DEPTH];
    logic [RAW_W-1:0] rdidx [DEPTH];

    logic alc_fire;
    logic rtr_fire;

    assign oitf_empty = (alc_ptr == rtr_ptr);
    assign oitf_full  = (alc_ptr[PTR_W-1:0] == rtr_ptr[PTR_W-1:0]) &&
                        (alc_ptr[PTR_W] != rtr_ptr[PTR_W]);

    assign dis_ptr = alc_ptr[PTR_W-1:0];
    assign ret_ptr = rtr_ptr[PTR_W-1:0];

    // Gated by the registered flags, so a full FIFO drops the allocate even when retiring.
    assign alc_fire = dis_ena && !oitf_full;
    assign rtr_fire = ret_ena && !oitf_empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alc_ptr <= '0;
            rtr_ptr <= '0;
            vld     <= '0;
        end else begin
            if (rtr_fire) begin
                vld[ret_ptr] <= 1'b0;
                rtr_ptr      <= rtr_ptr + PTR_ONE;
            end
            if (alc_fire) begin
                vld[dis_ptr] <= 1'b1;
                alc_ptr      <= alc_ptr + PTR_ONE;
            end
        end
    end

    // NOTE: payload storage is deliberately unreset; vld alone qualifies every read.
    always_ff @(posedge clk) begin
        if (alc_fire) begin
            rdwen[dis_ptr] <= dis_rdwen;
            rdidx[dis_ptr] <= dis_rdidx;
        end
    end

    assign ret_rdwen = rdwen[ret_ptr];
    assign ret_rdidx = rdidx[ret_ptr];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        oitf_raw_dep = 1'b0;
        oitf_waw_dep = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && rdwen[i]) begin
                if (chk_rs1en && (rdidx[i] == chk_rs1idx) && (chk_rs1idx != '0))
                    oitf_raw_dep = 1'b1;
                if (chk_rs2en && (rdidx[i] == chk_rs2idx) && (chk_rs2idx != '0))
                    oitf_raw_dep = 1'b1;
                if (chk_rdwen && (rdidx[i] == chk_rdidx) && (chk_rdidx != '0))
                    oitf_waw_dep = 1'b1;
            end
        end
    end

endmodule
